// File: rtl/cse_shared_term_pipe.sv
// Two-stage valid/ready pipeline that computes t = a & b once per beat and fans it out to CHANNELS consumers.
// Optional macro SHARED_TERM_CACHE_EN adds a one-entry {a, b, t} cache that reuses t when a/b repeat.
module cse_shared_term_pipe #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_a,
    input  logic [WIDTH-1:0]          in_b,
    input  logic [CHANNELS*WIDTH-1:0] in_c,
    input  logic [CHANNELS*WIDTH-1:0] in_d,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out1,
    output logic [CHANNELS*WIDTH-1:0] out2,
    output logic [CNT_W-1:0]          term_count,
    output logic [CNT_W-1:0]          hit_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                      w_adv1;
    logic                      w_adv2;
    logic                      w_accept;
    logic                      w_hit;
    logic [WIDTH-1:0]          w_and;
    logic [WIDTH-1:0]          w_t;
    logic [CHANNELS*WIDTH-1:0] w_out1;
    logic [CHANNELS*WIDTH-1:0] w_out2;

    logic                      r_vld_p1;
    logic [WIDTH-1:0]          r_t_p1;
    logic [CHANNELS*WIDTH-1:0] r_c_p1;
    logic [CHANNELS*WIDTH-1:0] r_d_p1;
    logic                      r_vld_p2;
    logic [CHANNELS*WIDTH-1:0] r_out1_p2;
    logic [CHANNELS*WIDTH-1:0] r_out2_p2;
    logic [CNT_W-1:0]          r_term_cnt;

    assign w_adv2   = !r_vld_p2 || out_ready;
    assign w_adv1   = !r_vld_p1 || w_adv2;
    assign w_accept = in_valid && w_adv1;
    assign w_and    = in_a & in_b;

`ifdef SHARED_TERM_CACHE_EN
    logic             r_cache_vld;
    logic [WIDTH-1:0] r_cache_a;
    logic [WIDTH-1:0] r_cache_b;
    logic [WIDTH-1:0] r_cache_t;
    logic [CNT_W-1:0] r_hit_cnt;

    assign w_hit     = r_cache_vld && (in_a == r_cache_a) && (in_b == r_cache_b);
    assign w_t       = w_hit ? r_cache_t : w_and;
    assign hit_count = r_hit_cnt;

    // Only a miss refreshes the cache, so a hit never rewrites identical contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cache_vld <= 1'b0;
        end else if (w_accept && !w_hit) begin
            r_cache_vld <= 1'b1;
            r_cache_a   <= in_a;
            r_cache_b   <= in_b;
            r_cache_t   <= w_and;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt <= '0;
        end else if (w_accept && w_hit) begin
            r_hit_cnt <= sat_inc(r_hit_cnt);
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_t       = w_and;
    assign hit_count = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_term_cnt <= '0;
        end else if (w_accept && !w_hit) begin
            r_term_cnt <= sat_inc(r_term_cnt);
        end
    end

    // Stage 1: shared term plus per-channel operands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_adv1) begin
            r_vld_p1 <= w_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_t_p1 <= w_t;
            r_c_p1 <= in_c;
            r_d_p1 <= in_d;
        end
    end

    assign w_out1 = {CHANNELS{r_t_p1}} | r_c_p1;
    assign w_out2 = {CHANNELS{r_t_p1}} & r_d_p1;

    // Stage 2: per-channel results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_out1_p2 <= '0;
            r_out2_p2 <= '0;
        end else if (w_adv2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_out1_p2 <= w_out1;
                r_out2_p2 <= w_out2;
            end
        end
    end

    assign in_ready   = w_adv1;
    assign out_valid  = r_vld_p2;
    assign out1       = r_out1_p2;
    assign out2       = r_out2_p2;
    assign term_count = r_term_cnt;

endmodule

// File: tb/tb_cse_shared_term_pipe.sv
// Bench for cse_shared_term_pipe: queue-based reference model with per-cycle comparison,
// directed scenarios plus randomized traffic; a second instance with CNT_W=4 exercises saturation.
module tb_cse_shared_term_pipe;
    localparam int W  = 8;
    localparam int CH = 2;
    localparam int BW = W * CH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [BW-1:0] in_c = '0;
    logic [BW-1:0] in_d = '0;

    logic          in_ready, out_valid;
    logic [BW-1:0] out1, out2;
    logic [15:0]   term_count, hit_count;
    logic          in_ready4, out_valid4;
    logic [BW-1:0] out1_4, out2_4;
    logic [3:0]    term4, hit4;

    cse_shared_term_pipe #(.WIDTH(W), .CHANNELS(CH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid), .out_ready(out_ready), .out1(out1), .out2(out2),
        .term_count(term_count), .hit_count(hit_count));

    cse_shared_term_pipe #(.WIDTH(W), .CHANNELS(CH), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid4), .out_ready(out_ready), .out1(out1_4), .out2(out2_4),
        .term_count(term4), .hit_count(hit4));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [BW-1:0] o1;
        logic [BW-1:0] o2;
        int            acc;
    } beat_t;

    beat_t        q[$];
    int           cyc = 0;
    int           tc = 0;
    int           hc = 0;
    logic [W-1:0] ca = '0;
    logic [W-1:0] cb = '0;
    bit           cv = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic bit model_vis();
        return (q.size() > 0) && (q[0].acc + 1 < cyc);
    endfunction

    // Reference model: a FIFO of at most two in-flight beats; a beat becomes visible one edge after it is accepted.
    initial begin : model
        bit           mv, rdy;
        beat_t        nb;
        logic [W-1:0] t;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                tc = 0;
                hc = 0;
                cv = 1'b0;
            end else begin
                mv  = model_vis();
                rdy = (q.size() < 2) || out_ready;
                if (mv && out_ready) void'(q.pop_front());
                if (in_valid && rdy) begin
                    t = in_a & in_b;
                    nb.o1  = {CH{t}} | in_c;
                    nb.o2  = {CH{t}} & in_d;
                    nb.acc = cyc;
                    q.push_back(nb);
`ifdef SHARED_TERM_CACHE_EN
                    if (cv && in_a == ca && in_b == cb) begin
                        hc++;
                    end else begin
                        tc++;
                        ca = in_a;
                        cb = in_b;
                        cv = 1'b1;
                    end
`else
                    tc++;
`endif
                end
            end
            cyc++;
        end
    end

    initial begin : compare
        bit ev;
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                ev = model_vis();
                check("out_valid", {31'b0, out_valid}, {31'b0, ev});
                check("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < 2) || out_ready});
                check("out_valid4", {31'b0, out_valid4}, {31'b0, ev});
                check("in_ready4", {31'b0, in_ready4}, {31'b0, (q.size() < 2) || out_ready});
                if (ev) begin
                    check("out1", {16'b0, out1}, {16'b0, q[0].o1});
                    check("out2", {16'b0, out2}, {16'b0, q[0].o2});
                    check("out1_4", {16'b0, out1_4}, {16'b0, q[0].o1});
                    check("out2_4", {16'b0, out2_4}, {16'b0, q[0].o2});
                end
                check("term_count", {16'b0, term_count}, sat(tc, 65535));
                check("hit_count", {16'b0, hit_count}, sat(hc, 65535));
                check("term_count4", {28'b0, term4}, sat(tc, 15));
                check("hit_count4", {28'b0, hit4}, sat(hc, 15));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_term", {16'b0, term_count}, 32'd0);
        check("rst_hit", {16'b0, hit_count}, 32'd0);
        check("rst_out1", {16'b0, out1}, 32'd0);
        check("rst_out2", {16'b0, out2}, 32'd0);
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [BW-1:0] c, input logic [BW-1:0] d, output int waits);
        bit got;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_c = c;
        in_d = d;
        waits = 0;
        got = 1'b0;
        while (!got) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #2;
            if (!got) begin
                waits++;
                if (waits > 50) begin
                    checks++;
                    failures++;
                    $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 50 cycles");
                    got = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d beats left, required 0", q.size());
        end
        @(posedge clk);
        #2;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin : stim
        int w;
        out_ready = 1'b1;
        do_reset();
        chk_en = 1'b1;

        // Basic beat with hand-computed results
        drive(8'hF0, 8'h3C, 16'h8001, 16'h0FFF, w);
        @(posedge clk);
        #2;
        check("basic_valid", {31'b0, out_valid}, 32'd1);
        check("basic_out1", {16'b0, out1}, 32'h0000B031);
        check("basic_out2", {16'b0, out2}, 32'h00000030);
        check("basic_term", {16'b0, term_count}, 32'd1);
        drain();

        // Backpressure: two beats fill the pipe, the third waits
        do_reset();
        out_ready = 1'b0;
        drive(8'hF3, 8'h3F, 16'h4080, 16'hFFFF, w);
        check("bp_wait0", w, 0);
        drive(8'h0F, 8'hFF, 16'h1111, 16'h2222, w);
        check("bp_wait1", w, 0);
        in_valid = 1'b1;
        in_a = 8'h81;
        in_b = 8'h7E;
        in_c = 16'hAAAA;
        in_d = 16'h5555;
        repeat (3) @(posedge clk);
        #2;
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_hold_out1", {16'b0, out1}, 32'h000073B3);
        check("bp_hold_out2", {16'b0, out2}, 32'h00003333);
        out_ready = 1'b1;
        drive(8'h81, 8'h7E, 16'hAAAA, 16'h5555, w);
        drain();

        // Streaming with distinct a
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(8'(i * 16 + 1), 8'hFF, 16'($urandom), 16'($urandom), w);
            check("stream_no_stall", w, 0);
        end
        drain();
        check("stream_term", {16'b0, term_count}, 32'd10);
        check("stream_hit", {16'b0, hit_count}, 32'd0);

        // Repeated operands
        do_reset();
        for (int i = 0; i < 4; i++) drive(8'hAA, 8'h0F, 16'(i * 3), 16'hFFFF, w);
        drain();
`ifdef SHARED_TERM_CACHE_EN
        check("cache_term", {16'b0, term_count}, 32'd1);
        check("cache_hit", {16'b0, hit_count}, 32'd3);
`else
        check("cache_term", {16'b0, term_count}, 32'd4);
        check("cache_hit", {16'b0, hit_count}, 32'd0);
`endif

        // Reset with two beats stalled in flight
        do_reset();
        out_ready = 1'b0;
        drive(8'hAA, 8'h0F, 16'h1234, 16'h5678, w);
        drive(8'hAA, 8'h0F, 16'h9ABC, 16'hDEF0, w);
        do_reset();
        out_ready = 1'b1;
        drive(8'hAA, 8'h0F, 16'h0101, 16'h0202, w);
        drain();
        check("post_rst_term", {16'b0, term_count}, 32'd1);
        check("post_rst_hit", {16'b0, hit_count}, 32'd0);

        // Saturation of the narrow counter
        do_reset();
        for (int i = 0; i < 20; i++) drive(8'(i + 1), 8'hFF, 16'($urandom), 16'($urandom), w);
        drain();
        check("sat_term4", {28'b0, term4}, 32'd15);
        check("sat_term16", {16'b0, term_count}, 32'd20);
        drive(8'h77, 8'hFF, 16'h0, 16'h0, w);
        drain();
        check("sat_term4_hold", {28'b0, term4}, 32'd15);

        // Randomized traffic with a small operand set so repeats occur
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            case ($urandom % 3)
                0:       in_a = 8'hAA;
                1:       in_a = 8'h55;
                default: in_a = 8'hF0;
            endcase
            in_b = ($urandom % 2) != 0 ? 8'h0F : 8'hFF;
            in_c = 16'($urandom);
            in_d = 16'($urandom);
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
